sar_logic: RTL and testbench

// Successive-approximation controller directly downstream of comp. Consumes the

---
 rtl/sar_pkg.sv | 23 ++
 rtl/sar_decision.sv | 32 +++
 rtl/sar_logic.sv | 133 +++++++++++++
 tb/tb_sar_logic.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared definitions for the SAR controller.
//   state_t   : controller states IDLE, SAMPLE, EVAL, RESOLVE, DONE
//   DEC_ONE   : comparator decision {p,n} meaning "keep the trial bit"
//   DEC_ZERO  : comparator decision {p,n} meaning "clear the trial bit"
//   dec_invalid() : true for the two non-complementary decisions (00, 11)
package sar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    EVAL,
    RESOLVE,
    DONE
  } state_t;

  localparam logic [1:0] DEC_ONE  = 2'b10;
  localparam logic [1:0] DEC_ZERO = 2'b01;

  function automatic logic dec_invalid(input logic [1:0] dec);
    return (dec != DEC_ONE) && (dec != DEC_ZERO);
  endfunction

endpackage

// File: rtl/sar_decision.sv
// Comparator decision register.
//   clk, rst : system clock, asynchronous active-high reset
//   capture  : high during the EVAL cycle; the pair is latched on its exit edge
//   comp_p/n : comparator differential outputs
//   bit_val  : captured decision says "keep the trial bit"
//   invalid  : captured pair was 00 or 11
module sar_decision
  import sar_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic comp_p,
  input  logic comp_n,
  output logic bit_val,
  output logic invalid
);

  logic [1:0] dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec <= DEC_ZERO;
    end else if (capture) begin
      dec <= {comp_p, comp_n};
    end
  end

  assign bit_val = (dec == DEC_ONE);
  assign invalid = dec_invalid(dec);

endmodule

// File: rtl/sar_logic.sv
// Successive-approximation controller: samples, then resolves the DAC code
// MSB-first using one EVAL/RESOLVE cycle pair per bit, and presents the final
// code on result with a one-cycle valid strobe.
//   clk, rst      : system clock, asynchronous active-high reset
//   start         : conversion request, acted on only in IDLE
//   comp_p/comp_n : comparator decision inputs
//   comp_clk      : comparator clock (high = evaluate)
//   sample        : DAC bottom-plate sample switch enable
//   dac_p/dac_n   : DAC switch code and its complement
//   result, valid : last conversion result and its update strobe
//   busy          : from start acceptance through DONE
//   err           : sticky invalid-decision flag for the current/last conversion
module sar_logic
  import sar_pkg::*;
#(
  parameter int unsigned N_BITS        = 8,
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              comp_p,
  input  logic              comp_n,
  output logic              comp_clk,
  output logic              sample,
  output logic [N_BITS-1:0] dac_p,
  output logic [N_BITS-1:0] dac_n,
  output logic [N_BITS-1:0] result,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned CW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [CW-1:0]     cnt;
  logic [N_BITS-1:0] next_code;
  logic              bit_val;
  logic              invalid;

  sar_decision u_decision (
    .clk     (clk),
    .rst     (rst),
    .capture (state == EVAL),
    .comp_p  (comp_p),
    .comp_n  (comp_n),
    .bit_val (bit_val),
    .invalid (invalid)
  );

  // Resolved code for the RESOLVE cycle: settle bit idx from the captured
  // decision and, if bits remain, raise the next trial bit in the same edge
  // so it is already on the DAC when EVAL starts.
  always_comb begin
    next_code      = dac_p;
    next_code[idx] = bit_val;
    if (idx != '0) begin
      next_code[idx - IW'(1)] = 1'b1;
    end
  end

  assign dac_n = ~dac_p;

  // valid/result are set on the RESOLVE->DONE edge so the strobe and the new
  // result are both visible throughout the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= IW'(N_BITS - 1);
      cnt      <= '0;
      dac_p    <= '0;
      result   <= '0;
      comp_clk <= 1'b0;
      sample   <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SAMPLE;
            err    <= 1'b0;
            dac_p  <= '0;
            idx    <= IW'(N_BITS - 1);
            cnt    <= CW'(SAMPLE_CYCLES - 1);
            sample <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SAMPLE: begin
          if (cnt == '0) begin
            sample            <= 1'b0;
            dac_p[N_BITS-1]   <= 1'b1;
            comp_clk          <= 1'b1;
            state             <= EVAL;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        EVAL: begin
          comp_clk <= 1'b0;
          state    <= RESOLVE;
        end
        RESOLVE: begin
          dac_p <= next_code;
          if (invalid) begin
            err <= 1'b1;
          end
          if (idx != '0) begin
            idx      <= idx - IW'(1);
            comp_clk <= 1'b1;
            state    <= EVAL;
          end else begin
            result <= next_code;
            valid  <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          valid <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_logic.sv
// Self-checking bench for sar_logic (N_BITS=8, SAMPLE_CYCLES=2).
module tb_sar_logic;

  logic       clk;
  logic       rst;
  logic       start;
  logic       comp_p;
  logic       comp_n;
  logic       comp_clk;
  logic       sample;
  logic [7:0] dac_p;
  logic [7:0] dac_n;
  logic [7:0] result;
  logic       valid;
  logic       busy;
  logic       err;

  int checks   = 0;
  int failures = 0;

  int         vcycles[$];
  logic [7:0] last_res;
  logic       last_err;

  sar_logic #(.N_BITS(8), .SAMPLE_CYCLES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .comp_p   (comp_p),
    .comp_n   (comp_n),
    .comp_clk (comp_clk),
    .sample   (sample),
    .dac_p    (dac_p),
    .dac_n    (dac_n),
    .result   (result),
    .valid    (valid),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tgt;
    int         fbit;
    logic [7:0] exp_res;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // SAR against an ideal comparator p = (target >= code): each trial bit is
  // kept when the target reaches the trial code; a forced-invalid bit is
  // always cleared and flags an error.
  function automatic void ref_sar(input logic [7:0] tgt, input int fbit,
                                  output logic [7:0] res, output logic er);
    int unsigned code = 0;
    er = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      int unsigned trial = code + (1 << b);
      if (b == fbit) er = 1'b1;
      else if (int'(tgt) >= int'(trial)) code = trial;
    end
    res = code[7:0];
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_comp_clk"}, comp_clk, 0);
    check({tag, "_sample"},   sample,   0);
    check({tag, "_valid"},    valid,    0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_err"},      err,      0);
    check({tag, "_dac_p"},    dac_p,    8'h00);
    check({tag, "_dac_n"},    dac_n,    8'hFF);
    check({tag, "_result"},   result,   8'h00);
  endtask

  // One run: start accepted at edge t0; cycle c is the cycle after edge
  // t0+c-1. Observes outputs at each negedge, plays the comparator, and
  // optionally re-pulses or holds start.
  task automatic run(input logic [7:0] tgt, input int fbit, input bit hold,
                     input int rp1, input int rp2, input int ncyc);
    int bad_busy = 0, bad_sample = 0, bad_dacn = 0, bad_trial = 0, bad_cclk = 0, bad_err = 0;
    vcycles.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      int  ph;
      bit  is_eval;
      int  tbit;
      logic [7:0] one;
      @(negedge clk);
      ph      = hold ? ((c - 1) % 20) + 1 : c;
      is_eval = (ph >= 3) && (ph <= 18) && (ph % 2 == 1);
      tbit    = 7 - (ph - 3) / 2;
      if (busy !== ((ph >= 1) && (ph <= 19))) bad_busy++;
      if (sample !== (ph <= 2)) bad_sample++;
      if (dac_n !== ~dac_p) bad_dacn++;
      if (comp_clk !== is_eval) bad_cclk++;
      if (ph == 1 && err !== 1'b0) bad_err++;
      if (is_eval) begin
        one = 8'd1;
        if (dac_p[tbit] !== 1'b1 || (dac_p & ((one << tbit) - one)) != 8'h00) bad_trial++;
        if (tbit == fbit) begin
          comp_p = 1'b1;
          comp_n = 1'b1;
        end else begin
          comp_p = (tgt >= dac_p);
          comp_n = ~comp_p;
        end
      end else begin
        comp_p = 1'($urandom);
        comp_n = 1'($urandom);
      end
      if (valid === 1'b1) begin
        vcycles.push_back(c);
        last_res = result;
        last_err = err;
      end
      start = hold || (c == rp1) || (c == rp2);
    end
    start = 1'b0;
    check("busy_pattern",   bad_busy,   0);
    check("sample_pattern", bad_sample, 0);
    check("dac_n_compl",    bad_dacn,   0);
    check("comp_clk_pat",   bad_cclk,   0);
    check("trial_bits",     bad_trial,  0);
    check("err_cleared",    bad_err,    0);
  endtask

  task automatic check_valids(input string tag, input int exp_q[$]);
    check({tag, "_valid_count"}, vcycles.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check({tag, "_valid_cycle"}, (i < vcycles.size()) ? vcycles[i] : -1, exp_q[i]);
    end
  endtask

  initial begin
    vec_t       tbl[6];
    logic [7:0] mres;
    logic       merr;
    int         exp_one[$];
    int         exp_hold[$];

    tbl[0] = '{8'hA5, -1, 8'hA5, 1'b0};
    tbl[1] = '{8'h00, -1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, -1, 8'hFF, 1'b0};
    tbl[3] = '{8'hFF,  5, 8'hDF, 1'b1};
    tbl[4] = '{8'h3C,  0, 8'h3C, 1'b1};
    tbl[5] = '{8'h01, -1, 8'h01, 1'b0};
    exp_one  = '{19};
    exp_hold = '{19, 39, 59};

    rst    = 1'b1;
    start  = 1'b0;
    comp_p = 1'b0;
    comp_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      run(tbl[i].tgt, tbl[i].fbit, 1'b0, -1, -1, 22);
      check_valids("table", exp_one);
      check("table_result", last_res, tbl[i].exp_res);
      check("table_err",    last_err, tbl[i].exp_err);
      check("table_hold_result", result, tbl[i].exp_res);
    end

    // start re-pulsed while busy is ignored.
    run(8'h6B, -1, 1'b0, 3, 10, 24);
    check_valids("repulse", exp_one);
    check("repulse_result", last_res, 8'h6B);

    // start held high: back-to-back conversions every 20 cycles.
    run(8'hC3, -1, 1'b1, -1, -1, 60);
    check_valids("hold", exp_hold);
    check("hold_result", last_res, 8'hC3);
    repeat (3) @(negedge clk);
    check("hold_idle_busy", busy, 0);

    // Randomized targets and invalid-decision injection against the model.
    for (int k = 0; k < 16; k++) begin
      logic [7:0] t;
      int         fb;
      t  = 8'($urandom);
      fb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      ref_sar(t, fb, mres, merr);
      run(t, fb, 1'b0, -1, -1, 22);
      check_valids("rand", exp_one);
      check("rand_result", last_res, mres);
      check("rand_err",    last_err, merr);
    end

    // Asynchronous reset in the middle of an EVAL cycle.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    comp_p = 1'b1;
    comp_n = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_in_eval", comp_clk, 1);
    #1 rst = 1'b1;
    #1 check_reset_vals("midreset");
    @(negedge clk);
    rst = 1'b0;
    vcycles.delete();
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (valid === 1'b1) vcycles.push_back(c);
    end
    check("midreset_no_valid", vcycles.size(), 0);
    check("midreset_result",   result, 8'h00);
    run(8'h5A, -1, 1'b0, -1, -1, 22);
    check_valids("post_reset", exp_one);
    check("post_reset_result", last_res, 8'h5A);
    check("post_reset_err",    last_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
